// File: rtl/fir_mac_sequencer_if.sv
// Handshake, result and coefficient-configuration signals of the FIR MAC sequencer.
// The sample source / configuration agent uses the master modport; the sequencer uses slave.
interface fir_mac_sequencer_if #(
    parameter int N  = 128,
    parameter int DW = 17,
    parameter int OW = 32
);
    localparam int AW = $clog2(N);

    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] data_in;
    logic                 out_valid;
    logic signed [OW-1:0] data_out;
    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic signed [DW-1:0] coef_data;
    logic                 coef_drop;
    logic                 busy;

    modport master (
        output in_valid, data_in, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, data_out, coef_drop, busy
    );

    modport slave (
        input  in_valid, data_in, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, data_out, coef_drop, busy
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed N-tap FIR: one shared signed multiply-accumulate walks all taps,
// one tap per cycle, producing one result per accepted sample (N+2 cycles each).
module fir_mac_sequencer #(
    parameter int N  = 128,
    parameter int DW = 17,
    parameter int OW = 32
) (
    input  logic               clk,
    input  logic               rst,
    fir_mac_sequencer_if.slave bus
);
    localparam int AW = $clog2(N);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        k_q, k_d;
    logic signed [OW-1:0] acc_q, acc_d;
    logic signed [OW-1:0] data_out_q, data_out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 coef_drop_q, coef_drop_d;

    logic signed [DW-1:0] samp_buf_q [N];
    logic signed [DW-1:0] coef_mem   [N];

    logic                 buf_we;
    logic                 coef_wr;
    logic [AW-1:0]        rd_idx;
    logic signed [DW-1:0] samp_rd;
    logic signed [DW-1:0] coef_rd;
    logic signed [OW-1:0] prod;

    // Tap k reads the sample k positions back in history; the AW-bit subtraction wraps mod N.
    assign rd_idx  = wr_ptr_q - k_q;
    assign samp_rd = samp_buf_q[rd_idx];
    assign coef_rd = coef_mem[k_q];

    // Operands are sign-extended (or truncated) to OW before multiplying: the low OW bits
    // of that product equal the full 2*DW-bit product sign-extended/truncated to OW.
    assign prod = OW'(samp_rd) * OW'(coef_rd);

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.busy      = (state_q == MAC) || (state_q == DONE);
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.coef_drop = coef_drop_q;

    // Next-state, datapath updates and write strobes for the IDLE -> MAC -> DONE sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        k_d         = k_q;
        acc_d       = acc_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        coef_drop_d = bus.coef_we && (state_q != IDLE);
        buf_we      = 1'b0;
        coef_wr     = 1'b0;

        case (state_q)
            IDLE: begin
                coef_wr = bus.coef_we && !rst;
                if (bus.in_valid) begin
                    buf_we  = 1'b1;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + prod;
                k_d   = k_q + 1'b1;
                if (k_q == AW'(N - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                data_out_d  = acc_q;
                out_valid_d = 1'b1;
                wr_ptr_d    = wr_ptr_q + 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            coef_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            coef_drop_q <= coef_drop_d;
        end
    end

    // Sample history: cleared on reset so no stale samples leak into the next result.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                samp_buf_q[i] <= '0;
            end
        end else if (buf_we) begin
            samp_buf_q[wr_ptr_q] <= bus.data_in;
        end
    end

    // Coefficient memory: written only while idle.
    always_ff @(posedge clk) begin
        // NOTE: no reset branch on purpose -- coefficients survive reset and this maps to plain RAM.
        if (coef_wr) begin
            coef_mem[bus.coef_addr] <= bus.coef_data;
        end
    end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with N=4: a table of sample vectors plus
// hand-written backpressure, configuration-guard and mid-MAC reset sequences.
module tb_fir_mac_sequencer;
    localparam int N  = 4;
    localparam int DW = 17;
    localparam int OW = 32;

    typedef struct {
        string name;
        bit    restart;   // reset and load c0..c3 before this sample
        int    c0, c1, c2, c3;
        int    samp;
        int    expv;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fir_mac_sequencer_if #(.N(N), .DW(DW), .OW(OW)) bus ();

    fir_mac_sequencer #(.N(N), .DW(DW), .OW(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load_coefs(input int c0, input int c1, input int c2, input int c3);
        int c [4];
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        for (int k = 0; k < N; k++) begin
            bus.coef_we   = 1'b1;
            bus.coef_addr = 2'(k);
            bus.coef_data = DW'(c[k]);
            tick();
        end
        bus.coef_we = 1'b0;
    endtask

    // Waits for out_valid counting cycles from the acceptance edge (already cnt_start ticks in).
    task automatic wait_result(input string name, input int cnt_start, input int expv);
        int cnt;
        cnt = cnt_start;
        while (!bus.out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check({name, " latency"}, cnt, N + 1);
        check({name, " data_out"}, bus.data_out, expv);
        tick();
        check({name, " pulse width"}, bus.out_valid, 0);
    endtask

    task automatic send_check(input string name, input int samp, input int expv);
        int cnt;
        cnt = 0;
        while (!bus.in_ready && cnt < 10) begin
            tick();
            cnt++;
        end
        check({name, " in_ready"}, bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.data_in  = DW'(samp);
        tick();
        bus.in_valid = 1'b0;
        wait_result(name, 0, expv);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs [14];
        int   pulses;

        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst in_ready", bus.in_ready, 0);
        check("rst out_valid", bus.out_valid, 0);
        check("rst busy", bus.busy, 0);
        check("rst data_out", bus.data_out, 0);
        check("rst coef_drop", bus.coef_drop, 0);
        rst = 1'b0;
        tick();
        check("idle in_ready", bus.in_ready, 1);

        vecs[0]  = '{"impulse0", 1'b1, 1, 2, 3, 4, 1, 1};
        vecs[1]  = '{"impulse1", 1'b0, 0, 0, 0, 0, 0, 2};
        vecs[2]  = '{"impulse2", 1'b0, 0, 0, 0, 0, 0, 3};
        vecs[3]  = '{"impulse3", 1'b0, 0, 0, 0, 0, 0, 4};
        vecs[4]  = '{"impulse4", 1'b0, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{"step0", 1'b1, 1, 2, 3, 4, 1, 1};
        vecs[6]  = '{"step1", 1'b0, 0, 0, 0, 0, 1, 3};
        vecs[7]  = '{"step2", 1'b0, 0, 0, 0, 0, 1, 6};
        vecs[8]  = '{"step3", 1'b0, 0, 0, 0, 0, 1, 10};
        vecs[9]  = '{"step4", 1'b0, 0, 0, 0, 0, 1, 10};
        vecs[10] = '{"ovf0", 1'b1, 65535, 65535, 65535, 65535, 65535, -131071};
        vecs[11] = '{"ovf1", 1'b0, 0, 0, 0, 0, 65535, -262142};
        vecs[12] = '{"ovf2", 1'b0, 0, 0, 0, 0, 65535, -393213};
        vecs[13] = '{"ovf3", 1'b0, 0, 0, 0, 0, 65535, -524284};

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].restart) begin
                do_reset();
                load_coefs(vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].c3);
            end
            send_check(vecs[i].name, vecs[i].samp, vecs[i].expv);
        end

        // Signed product with in_valid held through the busy period
        do_reset();
        load_coefs(-1, 0, 0, 0);
        bus.in_valid = 1'b1;
        bus.data_in  = DW'(-65536);
        check("bp in_ready before", bus.in_ready, 1);
        tick();
        pulses = 0;
        for (int i = 0; i < N + 1; i++) begin
            check("bp in_ready busy", bus.in_ready, 0);
            check("bp busy", bus.busy, 1);
            if (bus.out_valid) pulses++;
            tick();
        end
        bus.in_valid = 1'b0;
        check("bp early pulses", pulses, 0);
        check("bp out_valid", bus.out_valid, 1);
        check("bp data_out", bus.data_out, 65536);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid) pulses++;
        end
        check("bp extra pulses", pulses, 0);
        check("bp busy after", bus.busy, 0);

        // Coefficient write while busy is dropped
        do_reset();
        load_coefs(1, 2, 3, 4);
        bus.in_valid = 1'b1;
        bus.data_in  = DW'(1);
        tick();
        bus.in_valid  = 1'b0;
        bus.coef_we   = 1'b1;
        bus.coef_addr = 2'd0;
        bus.coef_data = DW'(7);
        tick();
        bus.coef_we = 1'b0;
        check("guard coef_drop", bus.coef_drop, 1);
        tick();
        check("guard coef_drop end", bus.coef_drop, 0);
        wait_result("guard busy", 2, 1);
        do_reset();
        send_check("guard kept", 1, 1);

        // Coefficient write and sample acceptance in the same idle cycle
        do_reset();
        bus.coef_we   = 1'b1;
        bus.coef_addr = 2'd0;
        bus.coef_data = DW'(7);
        bus.in_valid  = 1'b1;
        bus.data_in   = DW'(1);
        tick();
        bus.coef_we  = 1'b0;
        bus.in_valid = 1'b0;
        check("guard idle coef_drop", bus.coef_drop, 0);
        wait_result("guard idle", 0, 7);
        send_check("guard idle1", 0, 2);
        send_check("guard idle2", 0, 3);
        send_check("guard idle3", 0, 4);

        // Reset in the middle of a MAC pass
        do_reset();
        load_coefs(1, 2, 3, 4);
        send_check("rmid pre", 5, 5);
        bus.in_valid = 1'b1;
        bus.data_in  = DW'(3);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rmid in_ready in rst", bus.in_ready, 0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.out_valid) pulses++;
            tick();
        end
        check("rmid pulses", pulses, 0);
        check("rmid busy", bus.busy, 0);
        check("rmid in_ready", bus.in_ready, 1);
        check("rmid data_out", bus.data_out, 0);
        send_check("rmid imp0", 1, 1);
        send_check("rmid imp1", 0, 2);
        send_check("rmid imp2", 0, 3);
        send_check("rmid imp3", 0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
